// File: rtl/image_receiver.sv
// BMP header parser and three-row line buffer feeding a Sobel stage one pixel column at a time.
// Rows live in three rotating slots; the slot due for overwrite always holds the oldest row.
module image_receiver #(
    parameter int MAX_WIDTH = 640,
    parameter int HDR_BYTES = 54
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read_header,
    input  logic        read_buffer,
    input  logic [7:0]  sd_data,
    input  logic        sd_valid,
    input  logic        sed_ready,
    output logic        rx_ready,
    output logic        header_valid,
    output logic        header_error,
    output logic [31:0] img_size,
    output logic [15:0] img_width,
    output logic [15:0] img_height,
    output logic        buffer_full,
    output logic        new_col,
    output logic [7:0]  col_top,
    output logic [7:0]  col_mid,
    output logic [7:0]  col_bot,
    output logic        eof
);

    localparam int          AW       = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
    localparam logic [15:0] MAX_W16  = 16'(MAX_WIDTH);
    localparam logic [15:0] LAST_HDR = 16'(HDR_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_CHECK, S_HDR_DONE, S_FILL, S_EMIT, S_DONE, S_ERR
    } state_t;

    state_t      r_state, w_state_next;

    logic        r_rh_d;
    logic [15:0] r_byte_cnt;
    logic [7:0]  r_sig0, r_sig1;
    logic [15:0] r_bpp;
    logic [31:0] r_size;
    logic [15:0] r_width, r_height;
    logic        r_header_valid, r_header_error;
    logic [1:0]  r_wr_row;
    logic [15:0] r_wr_col;
    logic [15:0] r_rows_rcvd;
    logic [15:0] r_rd_col;
    logic        r_new_col;
    logic [1:0]  r_sel;

    logic        w_rh_rise, w_accept, w_hdr_byte, w_pix_byte, w_row_end;
    logic        w_emit_req, w_last_col, w_legal, w_enter_hdr, w_rd_en;

    assign w_rh_rise   = read_header && !r_rh_d;
    assign w_accept    = sd_valid && rx_ready;
    assign w_hdr_byte  = w_accept && (r_state == S_HDR);
    assign w_pix_byte  = w_accept && (r_state == S_FILL);
    assign w_row_end   = w_pix_byte && (r_wr_col == r_width - 16'd1);
    assign w_emit_req  = (r_state == S_EMIT) && sed_ready;
    assign w_last_col  = w_emit_req && (r_rd_col == r_width - 16'd1);
    assign w_enter_hdr = (r_state != S_HDR) && (w_state_next == S_HDR);
    assign w_rd_en     = w_emit_req && !w_enter_hdr;
    assign w_legal     = (r_sig0 == 8'h42) && (r_sig1 == 8'h4D) && (r_bpp == 16'd8) &&
                         (r_width >= 16'd3) && (r_width <= MAX_W16) && (r_height >= 16'd3);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (read_header)                         w_state_next = S_HDR;
                else if (read_buffer && r_header_valid)  w_state_next = S_FILL;
            end
            S_HDR:      if (w_hdr_byte && r_byte_cnt == LAST_HDR) w_state_next = S_CHECK;
            S_CHECK:    w_state_next = w_legal ? S_HDR_DONE : S_ERR;
            S_HDR_DONE: w_state_next = read_buffer ? S_FILL : S_IDLE;
            // The third completed row (or any replacement after it) opens the emit window.
            S_FILL:     if (w_row_end && r_rows_rcvd >= 16'd2) w_state_next = S_EMIT;
            S_EMIT: begin
                if (w_last_col)
                    w_state_next = (r_rows_rcvd == r_height) ? S_DONE : S_FILL;
            end
            default:    w_state_next = r_state;
        endcase
        if (w_rh_rise && r_state != S_HDR) w_state_next = S_HDR;
    end

    always_comb begin
        rx_ready    = 1'b0;
        buffer_full = 1'b0;
        eof         = 1'b0;
        case (r_state)
            S_HDR:   rx_ready    = 1'b1;
            S_FILL:  rx_ready    = read_buffer;
            S_EMIT:  buffer_full = 1'b1;
            S_DONE:  eof         = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rh_d         <= 1'b0;
            r_byte_cnt     <= '0;
            r_sig0         <= '0;
            r_sig1         <= '0;
            r_bpp          <= '0;
            r_size         <= '0;
            r_width        <= '0;
            r_height       <= '0;
            r_header_valid <= 1'b0;
            r_header_error <= 1'b0;
            r_wr_row       <= '0;
            r_wr_col       <= '0;
            r_rows_rcvd    <= '0;
            r_rd_col       <= '0;
            r_new_col      <= 1'b0;
            r_sel          <= '0;
        end else begin
            r_rh_d    <= read_header;
            r_new_col <= w_rd_en;
            if (w_enter_hdr) begin
                r_byte_cnt     <= '0;
                r_sig0         <= '0;
                r_sig1         <= '0;
                r_bpp          <= '0;
                r_size         <= '0;
                r_width        <= '0;
                r_height       <= '0;
                r_header_valid <= 1'b0;
                r_header_error <= 1'b0;
                r_wr_row       <= '0;
                r_wr_col       <= '0;
                r_rows_rcvd    <= '0;
                r_rd_col       <= '0;
            end else begin
                if (w_hdr_byte) begin
                    r_byte_cnt <= r_byte_cnt + 16'd1;
                    case (r_byte_cnt)
                        16'd0:   r_sig0          <= sd_data;
                        16'd1:   r_sig1          <= sd_data;
                        16'd2:   r_size[7:0]     <= sd_data;
                        16'd3:   r_size[15:8]    <= sd_data;
                        16'd4:   r_size[23:16]   <= sd_data;
                        16'd5:   r_size[31:24]   <= sd_data;
                        16'd18:  r_width[7:0]    <= sd_data;
                        16'd19:  r_width[15:8]   <= sd_data;
                        16'd22:  r_height[7:0]   <= sd_data;
                        16'd23:  r_height[15:8]  <= sd_data;
                        16'd28:  r_bpp[7:0]      <= sd_data;
                        16'd29:  r_bpp[15:8]     <= sd_data;
                        default: ;
                    endcase
                end
                if (r_state == S_CHECK) begin
                    r_header_valid <= w_legal;
                    r_header_error <= !w_legal;
                end
                if (w_pix_byte) begin
                    if (w_row_end) begin
                        r_wr_col    <= '0;
                        r_wr_row    <= (r_wr_row == 2'd2) ? 2'd0 : r_wr_row + 2'd1;
                        r_rows_rcvd <= r_rows_rcvd + 16'd1;
                    end else begin
                        r_wr_col <= r_wr_col + 16'd1;
                    end
                end
                if (w_emit_req) begin
                    r_rd_col <= w_last_col ? 16'd0 : r_rd_col + 16'd1;
                    r_sel    <= r_wr_row;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_row
            logic [7:0] r_mem [MAX_WIDTH];
            logic [7:0] r_rd;

            always_ff @(posedge clk) begin
                if (w_pix_byte && r_wr_row == 2'(gi))
                    r_mem[r_wr_col[AW-1:0]] <= sd_data;
            end

            always_ff @(posedge clk) begin
                if (rst)          r_rd <= '0;
                else if (w_rd_en) r_rd <= r_mem[r_rd_col[AW-1:0]];
            end
        end
    endgenerate

    // r_sel is the oldest slot at read time; the other two follow in arrival order.
    always_comb begin
        col_top = g_row[0].r_rd;
        col_mid = g_row[1].r_rd;
        col_bot = g_row[2].r_rd;
        case (r_sel)
            2'd1: begin
                col_top = g_row[1].r_rd;
                col_mid = g_row[2].r_rd;
                col_bot = g_row[0].r_rd;
            end
            2'd2: begin
                col_top = g_row[2].r_rd;
                col_mid = g_row[0].r_rd;
                col_bot = g_row[1].r_rd;
            end
            default: ;
        endcase
    end

    assign header_valid = r_header_valid;
    assign header_error = r_header_error;
    assign img_size     = r_size;
    assign img_width    = r_width;
    assign img_height   = r_height;
    assign new_col      = r_new_col;

endmodule

// File: tb/tb_image_receiver.sv
// Directed bench for image_receiver: header parsing, legality checks, column emission,
// row replacement, stalls, ignored strobes and mid-row reset.
module tb_image_receiver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        read_header = 1'b0;
    logic        read_buffer = 1'b0;
    logic [7:0]  sd_data = 8'h00;
    logic        sd_valid = 1'b0;
    logic        sed_ready = 1'b0;
    logic        rx_ready, header_valid, header_error, buffer_full, new_col, eof;
    logic [31:0] img_size;
    logic [15:0] img_width, img_height;
    logic [7:0]  col_top, col_mid, col_bot;

    int n_checks = 0;
    int n_errors = 0;

    image_receiver #(.MAX_WIDTH(640), .HDR_BYTES(54)) dut (
        .clk(clk), .rst(rst), .read_header(read_header), .read_buffer(read_buffer),
        .sd_data(sd_data), .sd_valid(sd_valid), .sed_ready(sed_ready),
        .rx_ready(rx_ready), .header_valid(header_valid), .header_error(header_error),
        .img_size(img_size), .img_width(img_width), .img_height(img_height),
        .buffer_full(buffer_full), .new_col(new_col),
        .col_top(col_top), .col_mid(col_mid), .col_bot(col_bot), .eof(eof)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic put_byte(input logic [7:0] b);
        sd_data  = b;
        sd_valid = 1'b1;
        @(negedge clk);
        sd_valid = 1'b0;
    endtask

    task automatic pulse_rh();
        read_header = 1'b1;
        @(negedge clk);
        read_header = 1'b0;
    endtask

    task automatic send_header(input logic [7:0] b1, input logic [15:0] w,
                               input logic [15:0] h, input logic [31:0] size);
        logic [7:0] hdr [54];
        for (int i = 0; i < 54; i++) hdr[i] = 8'(i) ^ 8'hA5;
        hdr[0]  = 8'h42;      hdr[1]  = b1;
        hdr[2]  = size[7:0];  hdr[3]  = size[15:8];
        hdr[4]  = size[23:16]; hdr[5] = size[31:24];
        hdr[18] = w[7:0];     hdr[19] = w[15:8];
        hdr[22] = h[7:0];     hdr[23] = h[15:8];
        hdr[28] = 8'd8;       hdr[29] = 8'd0;
        for (int i = 0; i < 54; i++) put_byte(hdr[i]);
        $display("header sent: b1=%h w=%0d h=%0d size=%h", b1, w, h, size);
    endtask

    task automatic wait_hdr(input string tag);
        int k = 0;
        while (!(header_valid || header_error) && k < 4) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_latency_ok"}, 32'(k <= 2), 32'd1);
    endtask

    task automatic wait_rx(input string tag);
        int k = 0;
        while (!rx_ready && k < 4) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_rx_ready"}, 32'(rx_ready), 32'd1);
    endtask

    task automatic emit_col(input string tag, input logic [7:0] t, input logic [7:0] m,
                            input logic [7:0] b);
        sed_ready = 1'b1;
        @(negedge clk);
        sed_ready = 1'b0;
        chk({tag, "_new_col"}, 32'(new_col), 32'd1);
        chk({tag, "_cols"}, 32'({col_top, col_mid, col_bot}), 32'({t, m, b}));
        $display("column %s: %h %h %h", tag, col_top, col_mid, col_bot);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_flags", 32'({rx_ready, header_valid, header_error, buffer_full, new_col, eof}), 32'd0);
        chk("rst_cols", 32'({col_top, col_mid, col_bot}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Bad signature byte
        pulse_rh();
        send_header(8'h4E, 16'd4, 16'd3, 32'h66);
        wait_hdr("sig");
        chk("sig_error", 32'(header_error), 32'd1);
        chk("sig_valid", 32'(header_valid), 32'd0);

        // Width one past the maximum
        pulse_rh();
        send_header(8'h4D, 16'd641, 16'd3, 32'h66);
        wait_hdr("w641");
        chk("w641_error", 32'(header_error), 32'd1);
        chk("w641_valid", 32'(header_valid), 32'd0);

        // Legal 4x3 image
        pulse_rh();
        send_header(8'h4D, 16'd4, 16'd3, 32'h66);
        wait_hdr("h3");
        chk("h3_valid", 32'(header_valid), 32'd1);
        chk("h3_error", 32'(header_error), 32'd0);
        chk("h3_width", 32'(img_width), 32'd4);
        chk("h3_height", 32'(img_height), 32'd3);
        chk("h3_size", img_size, 32'h66);

        read_buffer = 1'b1;
        wait_rx("h3_fill");
        sed_ready = 1'b1;
        put_byte(8'h00);
        sed_ready = 1'b0;
        chk("sed_in_fill", 32'(new_col), 32'd0);
        for (int i = 1; i < 12; i++) put_byte(8'(i));
        chk("h3_full", 32'(buffer_full), 32'd1);
        chk("h3_emit_rx", 32'(rx_ready), 32'd0);
        emit_col("h3_c0", 8'h00, 8'h04, 8'h08);
        emit_col("h3_c1", 8'h01, 8'h05, 8'h09);
        emit_col("h3_c2", 8'h02, 8'h06, 8'h0A);
        emit_col("h3_c3", 8'h03, 8'h07, 8'h0B);
        chk("h3_eof", 32'(eof), 32'd1);
        @(negedge clk);
        chk("h3_post", 32'({new_col, buffer_full, eof, rx_ready}), 32'b0010);

        // Reset while filling row 1 at column 2
        pulse_rh();
        send_header(8'h4D, 16'd4, 16'd3, 32'h66);
        wait_hdr("rr");
        chk("rr_valid", 32'(header_valid), 32'd1);
        wait_rx("rr_fill");
        for (int i = 0; i < 6; i++) put_byte(8'h20 + 8'(i));
        rst = 1'b1;
        read_buffer = 1'b0;
        @(negedge clk);
        chk("midrst_flags", 32'({rx_ready, header_valid, header_error, buffer_full, new_col, eof}), 32'd0);
        chk("midrst_size", img_size, 32'd0);
        chk("midrst_dims", {img_width, img_height}, 32'd0);
        chk("midrst_cols", 32'({col_top, col_mid, col_bot}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Legal 4x4 image with stall, ignored bytes and row replacement
        pulse_rh();
        send_header(8'h4D, 16'd4, 16'd4, 32'h6A);
        wait_hdr("h4");
        chk("h4_valid", 32'(header_valid), 32'd1);
        chk("h4_height", 32'(img_height), 32'd4);
        chk("h4_size", img_size, 32'h6A);
        read_buffer = 1'b1;
        wait_rx("h4_fill");
        for (int i = 0; i < 6; i++) put_byte(8'(i));
        read_buffer = 1'b0;
        put_byte(8'h77);
        chk("stall_rx", 32'(rx_ready), 32'd0);
        read_buffer = 1'b1;
        for (int i = 6; i < 12; i++) put_byte(8'(i));
        chk("h4_full", 32'(buffer_full), 32'd1);
        put_byte(8'hEE);
        chk("emit_byte_nc", 32'(new_col), 32'd0);
        chk("emit_byte_full", 32'(buffer_full), 32'd1);
        emit_col("h4_c0", 8'h00, 8'h04, 8'h08);
        emit_col("h4_c1", 8'h01, 8'h05, 8'h09);
        emit_col("h4_c2", 8'h02, 8'h06, 8'h0A);
        emit_col("h4_c3", 8'h03, 8'h07, 8'h0B);
        chk("h4_refill", 32'({buffer_full, eof, rx_ready}), 32'b001);
        for (int i = 0; i < 4; i++) put_byte(8'h10 + 8'(i));
        chk("h4_full2", 32'(buffer_full), 32'd1);
        emit_col("h4_d0", 8'h04, 8'h08, 8'h10);
        emit_col("h4_d1", 8'h05, 8'h09, 8'h11);
        emit_col("h4_d2", 8'h06, 8'h0A, 8'h12);
        emit_col("h4_d3", 8'h07, 8'h0B, 8'h13);
        chk("h4_eof", 32'(eof), 32'd1);
        @(negedge clk);
        chk("h4_post", 32'({new_col, buffer_full, eof, rx_ready}), 32'b0010);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/image_receiver.md
IMAGE_RECEIVER -- requirements
Module: image_receiver

Interface
REQ-001 Parameter MAX_WIDTH, default 640, maximum image width in pixels (sizes the row stores).
REQ-002 Parameter HDR_BYTES, default 54, BMP header length in bytes.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 read_header  input  1  controller level: parse header bytes.
REQ-006 read_buffer  input  1  controller level: accept pixel bytes.
REQ-007 sd_data  input  8  byte from SD interface.
REQ-008 sd_valid  input  1  sd_data valid this cycle.
REQ-009 sed_ready  input  1  Sobel stage requests the next column.
REQ-010 rx_ready  output  1  byte accepted when sd_valid && rx_ready.
REQ-011 header_valid  output  1  header parsed and legal.
REQ-012 header_error  output  1  header parsed and illegal.
REQ-013 img_size  output  32  file size, header bytes 2-5, little-endian.
REQ-014 img_width  output  16  width, header bytes 18-19, little-endian.
REQ-015 img_height  output  16  height, header bytes 22-23, little-endian.
REQ-016 buffer_full  output  1  three rows resident; columns available.
REQ-017 new_col  output  1  one-cycle strobe: col_top/col_mid/col_bot valid.
REQ-018 col_top, col_mid, col_bot  output  8 each  one column across the three resident rows, oldest row on top.
REQ-019 eof  output  1  all img_height rows received and emitted.

Function
REQ-020 The FSM SHALL have states IDLE, HDR, CHECK, HDR_DONE, FILL, EMIT, DONE, ERR.
REQ-021 IDLE: read_header=1 -> HDR, byte count cleared; read_buffer=1 with header_valid=1 -> FILL.
REQ-022 HDR: rx_ready=1; each accepted byte increments byte count and updates the captured fields; on byte HDR_BYTES-1 accepted -> CHECK.
REQ-023 CHECK (one cycle): legal iff bytes 0,1 = 0x42,0x4D, bytes 28-29 = 8 (bpp), 3 <= width <= MAX_WIDTH, height >= 3; legal -> HDR_DONE, else -> ERR.
REQ-024 header_valid SHALL be 1 from HDR_DONE entry until rst or the next read_header rising edge; header_error likewise from ERR entry.
REQ-025 Header bytes beyond those named in REQ-013..REQ-015 and REQ-023 are consumed and discarded.
REQ-026 FILL: rx_ready=1; byte written to row slot wr_row at column wr_col; wr_col wraps width-1 -> 0 and advances wr_row mod 3.
REQ-027 FILL -> EMIT on the cycle after three rows are resident (initially rows 0-2; thereafter after each replacement row); buffer_full=1 throughout EMIT only.
REQ-028 EMIT: rx_ready=0; on sed_ready=1 the block outputs column rd_col next cycle with new_col=1 (latency 1); rd_col increments; at most one column per cycle.
REQ-029 After column width-1 is emitted: if rows received = img_height -> DONE, else -> FILL to replace the oldest row, which becomes col_bot; top/mid shift down one slot logically.
REQ-030 DONE: eof=1 held, rx_ready=0, until rst or read_header rising edge (-> HDR).
REQ-031 read_buffer deasserted in FILL SHALL stall intake (rx_ready=0) without losing position; read_header rising edge in any state except HDR restarts header parsing and clears all pixel state.
REQ-032 sd_valid with rx_ready=0 SHALL be ignored; sed_ready outside EMIT SHALL be ignored.
REQ-033 Row/column counters SHALL be 16 bits; comparisons against img_width/img_height are unsigned.

Reset
REQ-034 rst=1 at a rising edge SHALL force IDLE, all counters 0, and every output 0 (header fields, col_* included), in any state including mid-header and mid-row.
REQ-035 Row store contents need not be cleared by reset.

Verification
REQ-036 54-byte header, 'BM', width 4, height 3, bpp 8, size 0x00000066 -> header_valid=1 within 2 cycles of last byte, img_width=4, img_height=3, img_size=0x66.
REQ-037 Header with byte 1 = 0x4E -> header_error=1, header_valid=0; width 641 likewise -> header_error=1.
REQ-038 After REQ-036, stream 12 bytes 0x00..0x0B in FILL -> buffer_full=1; four sed_ready pulses -> columns (00,04,08),(01,05,09),(02,06,0A),(03,07,0B), each with one new_col, then eof=1.
REQ-039 Height 4: after first 4 columns, stream 0x10..0x13 -> columns (04,08,10)...(07,0B,13), then eof=1.
REQ-040 rst asserted mid-FILL (row 1, col 2) -> next cycle all outputs 0, state IDLE; new read_header parses cleanly.
REQ-041 sd_valid pulses during EMIT and sed_ready during FILL -> no byte written, no new_col.
